// File: rtl/relu_share_gen_pkg.sv
// Shared definitions for the ReLU input masker: per-width default LFSR taps
// and the seeding FSM encoding.
package relu_share_gen_pkg;

    localparam logic [0:0] ST_UNSEEDED = 1'b0;
    localparam logic [0:0] ST_RUN      = 1'b1;

    // Galois taps for the 2N-bit mask LFSR, indexed by element width N.
    function automatic logic [31:0] default_poly(input int n);
        case (n)
            16:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/relu_share_gen_if.sv
// Input element stream and masked output word stream of relu_share_gen.
interface relu_share_gen_if #(
    parameter int N = 8
);
    logic [N-1:0]   in_x;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [2*N-1:0] g_output;
    logic [N-1:0]   e_output;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    modport slave (
        input  in_x, in_valid, in_last, out_ready,
        output in_ready, g_output, e_output, out_last, out_valid
    );

    modport master (
        output in_x, in_valid, in_last, out_ready,
        input  in_ready, g_output, e_output, out_last, out_valid
    );
endinterface

// File: rtl/relu_mask_lfsr.sv
// Galois LFSR that supplies mask pairs; advances only on step, and a zero
// seed is replaced by 1 so the lock-up state can never be entered.
module relu_mask_lfsr #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = 16'hB400
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         step,
    output logic [W-1:0] state
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_value == '0) ? W'(1) : load_value;
        end else if (step) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? POLY : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/relu_share_gen.sv
// Streaming masker: splits each element x into a garbler word {r1, r2} and an
// evaluator word x - r1, with fresh LFSR masks per element and vector framing.
module relu_share_gen
    import relu_share_gen_pkg::*;
#(
    parameter int               N    = 8,
    parameter logic [2*N-1:0]   POLY = (2*N)'(default_poly(N)),
    parameter int               CW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [2*N-1:0]    seed_value,
    output logic [CW-1:0]     vec_len,
    output logic              vec_done,
    output logic              seeded,
    relu_share_gen_if.slave   bus
);

    logic [0:0]     state_q;
    logic [0:0]     state_d;
    logic [2*N-1:0] lfsr_state;
    logic [2*N-1:0] g_q;
    logic [N-1:0]   e_q;
    logic           last_q;
    logic           valid_q;
    logic [CW-1:0]  elem_cnt_q;
    logic [CW-1:0]  vec_len_q;
    logic           vec_done_q;
    logic           accept;

    assign state_d = seed_load ? ST_RUN : state_q;
    assign seeded  = (state_q == ST_RUN);

    // Seed loads block acceptance so a new seed never races a mask draw.
    assign bus.in_ready = seeded && !seed_load && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    relu_mask_lfsr #(
        .W    (2*N),
        .POLY (POLY)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (seed_load),
        .load_value (seed_value),
        .step       (accept),
        .state      (lfsr_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_UNSEEDED;
            g_q        <= '0;
            e_q        <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            elem_cnt_q <= '0;
            vec_len_q  <= '0;
            vec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_done_q <= 1'b0;
            if (seed_load) begin
                elem_cnt_q <= '0;
            end
            if (accept) begin
                g_q     <= lfsr_state;
                e_q     <= bus.in_x - lfsr_state[2*N-1:N];
                last_q  <= bus.in_last;
                valid_q <= 1'b1;
                if (bus.in_last) begin
                    vec_len_q  <= elem_cnt_q + CW'(1);
                    elem_cnt_q <= '0;
                    vec_done_q <= 1'b1;
                end else begin
                    elem_cnt_q <= elem_cnt_q + CW'(1);
                end
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.g_output  = g_q;
    assign bus.e_output  = e_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;
    assign vec_len       = vec_len_q;
    assign vec_done      = vec_done_q;

endmodule

// File: tb/tb_relu_share_gen.sv
// Self-checking bench for relu_share_gen: directed scenarios plus a random
// stream, compared against a transaction-level scoreboard model.
module tb_relu_share_gen;

    typedef struct packed {
        logic [15:0] g;
        logic [7:0]  e;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_value = '0;
    logic [15:0] vec_len;
    logic        vec_done;
    logic        seeded;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    bit          seeded_m;
    logic [15:0] cnt_m;
    logic [15:0] veclen_m;
    word_t       pend[$];
    logic [15:0] obs_g[$];
    logic [7:0]  obs_e[$];
    int          done_cnt;

    relu_share_gen_if #(.N(8)) bus ();

    relu_share_gen #(.N(8), .POLY(16'hB400), .CW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .vec_len    (vec_len),
        .vec_done   (vec_done),
        .seeded     (seeded),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_clear();
        lfsr_m   = '0;
        seeded_m = 0;
        cnt_m    = '0;
        veclen_m = '0;
        pend.delete();
        obs_g.delete();
        obs_e.delete();
        done_cnt = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ovalid"}, 32'(bus.out_valid), 0);
        chk({tag, "_g"}, 32'(bus.g_output), 0);
        chk({tag, "_e"}, 32'(bus.e_output), 0);
        chk({tag, "_olast"}, 32'(bus.out_last), 0);
        chk({tag, "_veclen"}, 32'(vec_len), 0);
        chk({tag, "_vdone"}, 32'(vec_done), 0);
        chk({tag, "_seeded"}, 32'(seeded), 0);
        chk({tag, "_irdy"}, 32'(bus.in_ready), 0);
    endtask

    // One clock of stimulus; the model predicts handshakes from the transaction
    // rules and the scoreboard holds the at-most-one pending output word.
    task automatic step(input bit v, input logic [7:0] x, input bit l,
                        input bit ordy, input bit sl, input logic [15:0] sv);
        bit    acc;
        bit    exp_rdy;
        word_t w;
        bus.in_valid  = v;
        bus.in_x      = x;
        bus.in_last   = l;
        bus.out_ready = ordy;
        seed_load     = sl;
        seed_value    = sv;
        #1;
        exp_rdy = seeded_m && !sl && (pend.size() == 0 || ordy);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        if (pend.size() != 0 && ordy) begin
            obs_g.push_back(bus.g_output);
            obs_e.push_back(bus.e_output);
            void'(pend.pop_front());
        end
        if (acc) begin
            w.g    = lfsr_m;
            w.e    = x - lfsr_m[15:8];
            w.last = l;
            pend.push_back(w);
            lfsr_m = lfsr_next(lfsr_m);
            if (l) begin
                veclen_m = cnt_m + 16'd1;
                cnt_m    = '0;
            end else begin
                cnt_m = cnt_m + 16'd1;
            end
        end
        if (sl) begin
            lfsr_m   = (sv == 16'h0000) ? 16'h0001 : sv;
            seeded_m = 1;
            cnt_m    = '0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(pend.size() != 0));
        if (pend.size() != 0) begin
            chk("g_output", 32'(bus.g_output), 32'(pend[0].g));
            chk("e_output", 32'(bus.e_output), 32'(pend[0].e));
            chk("out_last", 32'(bus.out_last), 32'(pend[0].last));
        end
        chk("vec_done", 32'(vec_done), 32'(acc && l));
        if (vec_done === 1'b1) done_cnt++;
        chk("vec_len", 32'(vec_len), 32'(veclen_m));
        chk("seeded", 32'(seeded), 32'(seeded_m));
        seed_load = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_clear();
        chk_all_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        #2;
        chk_all_zero("por");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Unseeded: valid data must never be accepted.
        for (int i = 0; i < 5; i++) step(1, 8'h33, 0, 1, 0, '0);

        // Seed 1, stream three elements with the consumer always ready.
        step(0, 8'h00, 0, 1, 1, 16'h0001);
        step(1, 8'h05, 0, 1, 0, '0);
        step(1, 8'h10, 0, 1, 0, '0);
        step(1, 8'h20, 1, 1, 0, '0);
        step(0, 8'h00, 0, 1, 0, '0);
        chk("stream_len", 32'(obs_g.size()), 3);
        if (obs_g.size() == 3) begin
            chk("w1_g", 32'(obs_g[0]), 32'h0001);
            chk("w1_e", 32'(obs_e[0]), 32'h05);
            chk("w2_g", 32'(obs_g[1]), 32'hB400);
            chk("w2_e", 32'(obs_e[1]), 32'h5C);
            chk("w3_g", 32'(obs_g[2]), 32'h5A00);
            chk("w3_e", 32'(obs_e[2]), 32'hC6);
        end
        chk("vec3_len", 32'(vec_len), 3);
        chk("vec3_done_pulses", 32'(done_cnt), 1);

        // Backpressure for 5 cycles after the first accept, then release.
        obs_g.delete();
        obs_e.delete();
        step(0, 8'h00, 0, 1, 1, 16'h0001);
        step(1, 8'h05, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(1, 8'h10, 0, 0, 0, '0);
        step(1, 8'h10, 0, 1, 0, '0);
        step(1, 8'h20, 0, 1, 0, '0);
        step(0, 8'h00, 0, 1, 0, '0);
        chk("bp_len", 32'(obs_g.size()), 3);
        if (obs_g.size() == 3) begin
            chk("bp_w1_g", 32'(obs_g[0]), 32'h0001);
            chk("bp_w2_g", 32'(obs_g[1]), 32'hB400);
            chk("bp_w3_e", 32'(obs_e[2]), 32'hC6);
        end

        // Zero seed behaves as seed 1.
        obs_g.delete();
        obs_e.delete();
        step(0, 8'h00, 0, 1, 1, 16'h0000);
        step(1, 8'h07, 0, 1, 0, '0);
        step(0, 8'h00, 0, 1, 0, '0);
        if (obs_g.size() == 1) chk("seed0_g", 32'(obs_g[0]), 32'h0001);
        else chk("seed0_len", 32'(obs_g.size()), 1);

        // Reseed while valid is held: no accept that cycle, new seed used next.
        obs_g.delete();
        obs_e.delete();
        step(1, 8'h40, 0, 1, 0, '0);
        step(1, 8'h41, 0, 1, 1, 16'h1234);
        step(1, 8'h42, 1, 1, 0, '0);
        step(0, 8'h00, 0, 1, 0, '0);
        if (obs_g.size() == 2) chk("reseed_g", 32'(obs_g[1]), 32'h1234);
        else chk("reseed_len", 32'(obs_g.size()), 2);
        chk("reseed_veclen", 32'(vec_len), 1);

        // Random traffic with occasional reseeds.
        step(0, 8'h00, 0, 1, 1, 16'($urandom));
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3, 0) != 0), 8'($urandom), ($urandom_range(7, 0) == 0),
                 ($urandom_range(3, 0) != 0), ($urandom_range(39, 0) == 0), 16'($urandom));
        end

        // Asynchronous reset mid-stream with a word pending.
        step(1, 8'h99, 0, 0, 0, '0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 8'h55, 0, 1, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_share_gen.md
Name: relu_share_gen

Overview:
- Streaming input-side masker for the garbled ReLU datapath; the producer end of the interface the relu block consumes.
- For each plaintext element x it draws a fresh mask pair {r1, r2} from an internal LFSR.
- Emits the garbler word g_output = {r1, r2} and the evaluator word e_output = x - r1 (mod 2^N).
- Valid/ready on both sides. Output is one register stage with vector framing via last.

Parameters:
N, 8, element bit-width; matches relu N.
POLY, 16'hB400, Galois feedback taps for the 2N-bit LFSR (x^16+x^14+x^13+x^11+1 at N=8).
CW, 16, element-counter width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
seed_load  in  1  one-cycle pulse: load LFSR from seed_value
seed_value  in  2N  LFSR seed; 0 is replaced by 1
in_x  in  N  plaintext element
in_valid  in  1  in_x/in_last valid
in_last  in  1  final element of current vector
in_ready  out  1  element accepted when in_valid && in_ready
g_output  out  2N  {r1, r2} for garbler: r1 in [2N-1:N], r2 in [N-1:0]
e_output  out  N  x - r1 mod 2^N, for evaluator
out_last  out  1  registered copy of in_last
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts when out_valid && out_ready
vec_len  out  CW  element count of last completed vector
vec_done  out  1  one-cycle pulse when the in_last element is accepted
seeded  out  1  LFSR holds a loaded seed

Behaviour:
- Reset (rst=0, async): state UNSEEDED; lfsr=0; seeded=0; out_valid=0; g_output=0; e_output=0; out_last=0; elem_cnt=0; vec_len=0; vec_done=0; in_ready=0.
- FSM:
  - UNSEEDED --seed_load--> RUN.
  - RUN --seed_load--> RUN (reseed).
  - No other transitions.
- Seed load:
  - lfsr <= (seed_value==0) ? 1 : seed_value.
  - elem_cnt <= 0; seeded <= 1.
  - in_ready is forced 0 in any cycle seed_load=1, so no element is accepted that cycle.
  - The output register is untouched; a pending word stays valid until consumed.
- in_ready = seeded && !seed_load && (!out_valid || out_ready). Combinational, with no dependency on in_valid.
- On accept:
  - r1 = lfsr[2N-1:N]; r2 = lfsr[N-1:0] (current state).
  - Next cycle: g_output <= lfsr; e_output <= in_x - r1 (drop borrow); out_last <= in_last; out_valid <= 1.
  - lfsr <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 0).
  - Latency: 1 cycle input accept to out_valid.
  - Throughput: 1 element/cycle when out_ready is held high.
- out_valid clears after a consumer handshake with no new accept in the same cycle. Accept and consume in the same cycle keeps out_valid=1 and the register holds the new word.
- Output stability: while out_valid && !out_ready, g_output, e_output and out_last are held stable and the LFSR does not advance.
- Counter:
  - Each accept increments elem_cnt; it wraps at 2^CW silently.
  - Accept with in_last: vec_len <= elem_cnt+1 (mod 2^CW); elem_cnt <= 0; vec_done <= 1 for one cycle.
- LFSR never advances except on accept. The all-zero state is unreachable.
- Reset mid-stream discards the pending output word and the seed; re-seeding is mandatory.

Decomposition:
- Shared package: default POLY per supported N (8 -> 16'hB400, 16 -> 32'h80200003), and the FSM state encoding (UNSEEDED=0, RUN=1).
- One sub-module, relu_mask_lfsr: parameters W=2N and POLY; inputs load, load_value, step; output state; zero-seed substitution inside.
- Subtraction and handshake stay in the top level.

Test Plan:
- Reset, then in_valid=1 without seed -> in_ready=0, out_valid=0 indefinitely; seeded=0.
- Seed 16'h0001, stream x=0x05,0x10,0x20 with out_ready=1:
  - word 1: g_output=0x0001, e_output=0x05
  - word 2: g_output=0xB400, e_output=0x5C
  - word 3: g_output=0x5A00, e_output=0xC6
  - each word appears 1 cycle after its accept.
- Same stream with out_ready=0 for 5 cycles after the first accept -> in_ready=0; word 1 held stable; LFSR stays at 0xB400; the stream resumes identically after release.
- Seed 0 -> behaves exactly as seed 1: first g_output=0x0001.
- Vector of 3 elements with in_last on the third -> vec_done pulses once, vec_len=3, out_last=1 on word 3 only.
- Pulse seed_load while in_valid=1 -> no accept that cycle; the next accept uses the new seed; elem_cnt restarts from 0.
- Assert rst mid-stream -> all outputs 0 immediately (async); seeded=0.
